// File: rtl/phy_tx_pkg.sv
// Shared PHY TX/RX symbol constants and state encoding (also used by the serial_to_par aligner).
// Pure declarations: no latency; no flow control.
package phy_tx_pkg;

  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COMMA_SYM = 8'hBC;

  localparam logic ST_INIT   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  typedef enum logic {
    S_INIT   = ST_INIT,
    S_ACTIVE = ST_ACTIVE
  } tx_state_e;

  // Real data only goes out once aligned; every other slot carries the comma.
  function automatic logic [SYM_W-1:0] pick_sym(
    input logic             is_active,
    input logic             vld,
    input logic [SYM_W-1:0] dat,
    input logic [SYM_W-1:0] comma
  );
    return (is_active && vld) ? dat : comma;
  endfunction

endpackage

// File: rtl/pts_shifter.sv
// 8:1 MSB-first shifter: sym_in sampled at the load edge, bit 7 visible right after it.
// No backpressure: a new symbol is taken every 8th cycle unconditionally.
module pts_shifter
  import phy_tx_pkg::*;
(
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic [SYM_W-1:0] sym_in,
  output logic             load,
  output logic             data_out,
  output logic             sym_start
);

  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [SYM_W-1:0] shreg_q, shreg_d;
  logic             data_out_q, data_out_d;
  logic             sym_start_q, sym_start_d;
  logic [2:0]       bit_idx;

  assign load    = (bit_cnt_q == 3'd0);
  assign bit_idx = 3'd7 - bit_cnt_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    shreg_d     = shreg_q;
    data_out_d  = shreg_q[bit_idx];
    sym_start_d = 1'b0;
    if (load) begin
      // Bit 7 goes straight to the output; the register only feeds bits 6..0.
      shreg_d     = sym_in;
      data_out_d  = sym_in[SYM_W-1];
      sym_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      data_out_q  <= 1'b0;
      sym_start_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      sym_start_q <= sym_start_d;
    end
  end

  assign data_out  = data_out_q;
  assign sym_start = sym_start_q;

endmodule

// File: rtl/par_to_serial.sv
// PHY TX serializer: comma preamble after reset, then muxed symbols MSB first; PTS_BYTE_COUNT_EN adds byte_count.
// Latency: data_in sampled at the load edge, bit 7 on data_out right after it; no backpressure, upstream gates on active.
module par_to_serial
  import phy_tx_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA       = COMMA_SYM,
  parameter int               INIT_COMMAS = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic [SYM_W-1:0] data_in,
  input  logic             valid_in,
  output logic             data_out,
  output logic             sym_start,
  output logic             active
`ifdef PTS_BYTE_COUNT_EN
  ,
  output logic [15:0]      byte_count
`endif
);

  localparam logic [3:0] PRE_LAST = 4'(INIT_COMMAS - 1);

  tx_state_e        state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic             active_q, active_d;
  logic             load;
  logic [SYM_W-1:0] sym;

  assign sym = pick_sym(state_q == S_ACTIVE, valid_in, data_in, COMMA);

  pts_shifter u_shifter (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .sym_in    (sym),
    .load      (load),
    .data_out  (data_out),
    .sym_start (sym_start)
  );

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    active_d  = active_q;
    if (load && state_q == S_INIT) begin
      if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
      // The edge loading the last preamble comma already flips to ACTIVE.
      if (pre_cnt_q == PRE_LAST) begin
        state_d  = S_ACTIVE;
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q   <= S_INIT;
      pre_cnt_q <= 4'd0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      active_q  <= active_d;
    end
  end

  assign active = active_q;

`ifdef PTS_BYTE_COUNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (load && state_q == S_ACTIVE && valid_in) byte_cnt_d = byte_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) byte_cnt_q <= 16'd0;
    else          byte_cnt_q <= byte_cnt_d;
  end

  assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_par_to_serial.sv
// Scoreboard bench for par_to_serial: driver queues expected symbols, negedge monitor deserializes and compares.
module tb_par_to_serial;

  logic       clk_32f  = 1'b0;
  logic       reset_L  = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out, sym_start, active;
`ifdef PTS_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  par_to_serial dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .sym_start (sym_start),
    .active    (active)
`ifdef PTS_BYTE_COUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic       rst_at_edge = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;

  always @(posedge clk_32f) rst_at_edge <= reset_L;

  // Monitor: rebuilds each symbol from data_out, expects sym_start only on bit 7.
  always @(negedge clk_32f) begin
    if (mon_en) begin
      if (!rst_at_edge) begin
        mon_cnt = 0;
      end else begin
        checks++;
        if (sym_start !== (mon_cnt == 0)) begin
          errors++;
          $display("FAIL framing: sym_start=%0b required %0b at bit position %0d", sym_start, (mon_cnt == 0), mon_cnt);
        end
        mon_byte = {mon_byte[6:0], data_out};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_symbol: got %02h with nothing queued", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_byte !== mon_exp) begin
              errors++;
              $display("FAIL symbol: serial=%02h required %02h", mon_byte, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  // Called just before a load edge; covers that slot's 8 edges.
  task automatic send_slot(input logic [7:0] d, input logic v, input logic [7:0] exp);
    data_in  = d;
    valid_in = v;
    exp_q.push_back(exp);
    repeat (8) tick();
  endtask

  task automatic send_toggle(input logic [7:0] d, input logic v_load, input logic [7:0] exp);
    data_in  = d;
    valid_in = v_load;
    exp_q.push_back(exp);
    tick();
    valid_in = ~v_load;
    repeat (3) tick();
    valid_in = v_load;
    repeat (2) tick();
    valid_in = ~v_load;
    tick();
    tick();
  endtask

  task automatic preamble(input logic [7:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    repeat (4) exp_q.push_back(8'hBC);
    for (int e = 1; e <= 32; e++) begin
      tick();
      check($sformatf("active_edge%0d", e), int'(active), (e >= 25) ? 1 : 0);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } slot_t;

  slot_t cnt_tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cnt_tbl[0]  = '{8'h01, 1'b1}; cnt_tbl[1]  = '{8'h02, 1'b1}; cnt_tbl[2]  = '{8'hEE, 1'b0};
    cnt_tbl[3]  = '{8'h03, 1'b1}; cnt_tbl[4]  = '{8'h04, 1'b1}; cnt_tbl[5]  = '{8'h05, 1'b1};
    cnt_tbl[6]  = '{8'hDD, 1'b0}; cnt_tbl[7]  = '{8'h80, 1'b1}; cnt_tbl[8]  = '{8'hBC, 1'b1};
    cnt_tbl[9]  = '{8'h7F, 1'b1}; cnt_tbl[10] = '{8'hCC, 1'b0}; cnt_tbl[11] = '{8'hFE, 1'b1};
    cnt_tbl[12] = '{8'h10, 1'b1};

    reset_L = 1'b0;
    mon_en  = 1'b1;
    repeat (3) tick();
    check("reset_data_out", int'(data_out), 0);
    check("reset_sym_start", int'(sym_start), 0);
    check("reset_active", int'(active), 0);
`ifdef PTS_BYTE_COUNT_EN
    check("reset_byte_count", int'(byte_count), 0);
`endif

    // Preamble with valid data offered: must still be commas only.
    reset_L = 1'b1;
    preamble(8'h55, 1'b1);
`ifdef PTS_BYTE_COUNT_EN
    check("init_byte_count", int'(byte_count), 0);
`endif

    send_slot(8'hA5, 1'b1, 8'hA5);
    send_slot(8'hFF, 1'b0, 8'hBC);
    send_slot(8'hBC, 1'b1, 8'hBC);
    send_toggle(8'h3C, 1'b1, 8'h3C);
    send_toggle(8'hC3, 1'b0, 8'hBC);

    // Reset in the middle of a symbol (bit_cnt == 4); partial symbol is dropped.
    data_in  = 8'h3C;
    valid_in = 1'b1;
    repeat (4) tick();
    reset_L = 1'b0;
    tick();
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_sym_start", int'(sym_start), 0);
    check("midrst_active", int'(active), 0);
    reset_L = 1'b1;
    preamble(8'h3C, 1'b1);

    foreach (cnt_tbl[i])
      send_slot(cnt_tbl[i].d, cnt_tbl[i].v, cnt_tbl[i].v ? cnt_tbl[i].d : 8'hBC);
`ifdef PTS_BYTE_COUNT_EN
    check("byte_count_10", int'(byte_count), 10);
    dut.byte_cnt_q = 16'hFFFF;
    send_slot(8'h77, 1'b1, 8'h77);
    check("byte_count_wrap", int'(byte_count), 0);
`endif
    send_slot(8'h00, 1'b0, 8'hBC);
    send_slot(8'h81, 1'b1, 8'h81);

    @(negedge clk_32f);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
